div_iterative: RTL and testbench
================================

# div_iterative

Multi-cycle integer divider answering the execute stage's division request interface. Accepts a level-held enable with operands and a one-hot RV32M division op, runs a 32-step restoring shift-subtract algorithm, and returns a one-cycle ready pulse with the result. It sits beside the execute stage as the responder for `div_in`/`div_out`; the execute stage stalls until ready.

## Interface
- No parameters; data width fixed at 32.
- rst  in  1  synchronous, active-low reset
- clk  in  1  clock
- div_in  in  div_in_type  rdata1 (dividend, 32), rdata2 (divisor, 32), enable (1), op (div_op_type: div, divu, rem, remu, one-hot)
- div_out  out  div_out_type  ready (1), result (32)

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - enable=1: latch signed flag (op.div|op.rem), remainder-select flag (op.rem|op.remu), and operand signs.
  - Latch magnitudes: |x| if signed and negative, else raw.
  - Clear partial remainder, load counter=31, go BUSY.
  - enable=0: stay.
- BUSY, each cycle:
  - rem' = {rem[30:0], dvd[31]}; dvd shifts left.
  - If rem' ≥ divisor magnitude (33-bit compare, unsigned): subtract, shift quotient bit 1; else shift 0.
  - Counter 0: go DONE, else decrement.
  - enable=0 in any BUSY cycle: abort to IDLE, no ready.
- DONE:
  - ready=1, result = corrected quotient or remainder; next state IDLE unconditionally.
  - Correction: quotient negated when signed, signs differ and divisor≠0; remainder negated when signed and dividend negative.
- Special cases, RISC-V M semantics:
  - Divisor 0: quotient 0xFFFFFFFF, remainder = dividend.
  - Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- Operands are sampled only in IDLE; changes on rdata1/rdata2/op during BUSY/DONE are ignored.
- New enable in IDLE directly after DONE starts a fresh operation; no back-to-back merge.

## Timing
- Reset: state IDLE, ready=0, result=0, counter=0, all datapath registers 0.
- enable first seen in IDLE at cycle N -> ready=1 at cycle N+33 (1 load cycle + 32 iterations), for exactly one cycle.
- ready and result are registered outputs; result holds its last value after ready drops.
- Reset asserted mid-operation: IDLE next edge, no ready.
- Abort at any BUSY cycle: IDLE next edge; re-enable restarts from operand sampling, full latency.
- enable=0 during DONE: ready still asserted that cycle; execute is expected to ignore it.

## Configuration
- `DIV_EARLY_OUT_EN` defined:
  - Divide-by-zero, signed overflow, and unsigned |dividend| < |divisor| skip BUSY.
  - These go IDLE -> DONE with the final result, so ready comes at N+1.
- Undefined: every operation takes the full N+33 path. Special-case results are still forced in DONE and stay identical.

## Structure
- `wires` package: div_in_type, div_out_type (existing), plus div_reg_type holding state, counter, dividend, divisor, partial remainder, quotient and flags.
- `constants` package: init_div_reg, div_state_type enum (IDLE/BUSY/DONE).
- One combinational sub-module, `div_step`: 33-bit compare-subtract plus shift for one iteration.

## Test plan
- divu 100/7, enable held -> ready at N+33, result 14; remu same operands -> 2.
- div 0xFFFFFF9C (-100) / 7 -> 0xFFFFFFF2 (-14); rem -> 0xFFFFFFFE (-2).
- div 0x80000000 / 0xFFFFFFFF -> 0x80000000; rem -> 0. div 5/0 -> 0xFFFFFFFF; rem 5/0 -> 5. With `DIV_EARLY_OUT_EN`, ready at N+1.
- Start divu 1000/3, drop enable at N+10 -> no ready pulse. Re-enable at N+12 with 9/3 -> ready at N+45, result 3.
- Assert rst at N+5 mid-operation -> ready=0, result=0 next cycle; subsequent divu 8/2 -> 4 at normal latency.
- Back-to-back: divu 50/5 ready at N+33, enable at N+34 with remu 50/6 -> ready at N+67, result 2.

Source files
------------

// File: rtl/div_iterative_pkg.sv
// Shared types for the iterative divider: interface/register structs (wires)
// and the state encoding plus reset value (constants).
package wires;

    typedef struct packed {
        logic div;
        logic divu;
        logic rem;
        logic remu;
    } div_op_type;

    typedef struct packed {
        logic [31:0] rdata1;
        logic [31:0] rdata2;
        logic        enable;
        div_op_type  op;
    } div_in_type;

    typedef struct packed {
        logic        ready;
        logic [31:0] result;
    } div_out_type;

    typedef struct packed {
        logic [1:0]  state;
        logic [4:0]  counter;
        logic [31:0] dividend;
        logic [31:0] divisor;
        logic [31:0] remainder;
        logic [31:0] quotient;
        logic        sgn;
        logic        sel_rem;
        logic        neg_dvd;
        logic        neg_dvs;
        logic        ovf;
        logic        ready;
        logic [31:0] result;
    } div_reg_type;

endpackage

package constants;
    import wires::*;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_type;

    // IDLE encodes as zero, so the all-zero register is the reset value
    localparam div_reg_type init_div_reg = '0;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// subtract the divisor when the 33-bit partial remainder allows it.
module div_step (
    input  logic [31:0] rem,
    input  logic        dvd_msb,
    input  logic [31:0] dvs,
    output logic [31:0] rem_next,
    output logic        q_bit
);

    logic [32:0] rem_sh;

    always_comb begin
        rem_sh = {rem, dvd_msb};
        if (rem_sh >= {1'b0, dvs}) begin
            q_bit    = 1'b1;
            // difference is below the divisor, so it fits in 32 bits
            rem_next = rem_sh[31:0] - dvs;
        end else begin
            q_bit    = 1'b0;
            rem_next = rem_sh[31:0];
        end
    end

endmodule

// File: rtl/div_iterative.sv
// RV32M multi-cycle divider (div/divu/rem/remu), 32-step restoring algorithm.
// Define DIV_EARLY_OUT_EN to skip iteration for divide-by-zero, overflow and |a|<|b|.
module div_iterative
    import wires::*;
    import constants::*;
(
    input  logic        rst,
    input  logic        clk,
    input  div_in_type  div_in,
    output div_out_type div_out
);

    div_reg_type r_reg;
    div_reg_type r_next;

    logic        sgn_in;
    logic        sel_rem_in;
    logic        ovf_in;
    logic [31:0] dvd_abs;
    logic [31:0] dvs_abs;
    logic [31:0] step_rem;
    logic        step_q;
    logic [31:0] q_fix;
    logic [31:0] rem_fix;

    // op is one-hot; only a clean remainder encoding selects the remainder
    assign sgn_in     = div_in.op.div | div_in.op.rem;
    assign sel_rem_in = (div_in.op.rem | div_in.op.remu) & ~(div_in.op.div | div_in.op.divu);
    assign ovf_in     = sgn_in && (div_in.rdata1 == 32'h8000_0000) && (div_in.rdata2 == 32'hFFFF_FFFF);
    assign dvd_abs    = (sgn_in && div_in.rdata1[31]) ? -div_in.rdata1 : div_in.rdata1;
    assign dvs_abs    = (sgn_in && div_in.rdata2[31]) ? -div_in.rdata2 : div_in.rdata2;

    div_step u_step (
        .rem      (r_reg.remainder),
        .dvd_msb  (r_reg.dividend[31]),
        .dvs      (r_reg.divisor),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    // Sign correction plus RISC-V forced results for the special cases
    always_comb begin
        q_fix   = r_reg.quotient;
        rem_fix = r_reg.remainder;
        if (r_reg.sgn && (r_reg.neg_dvd != r_reg.neg_dvs) && (r_reg.divisor != 32'd0))
            q_fix = -r_reg.quotient;
        if (r_reg.sgn && r_reg.neg_dvd)
            rem_fix = -r_reg.remainder;
        if (r_reg.divisor == 32'd0)
            q_fix = 32'hFFFF_FFFF;
        if (r_reg.ovf) begin
            q_fix   = 32'h8000_0000;
            rem_fix = 32'd0;
        end
    end

    always_comb begin
        r_next = r_reg;
        case (r_reg.state)
            IDLE: begin
                r_next.ready = 1'b0;
                if (div_in.enable) begin
                    r_next.sgn       = sgn_in;
                    r_next.sel_rem   = sel_rem_in;
                    r_next.neg_dvd   = sgn_in & div_in.rdata1[31];
                    r_next.neg_dvs   = sgn_in & div_in.rdata2[31];
                    r_next.ovf       = ovf_in;
                    r_next.dividend  = dvd_abs;
                    r_next.divisor   = dvs_abs;
                    r_next.remainder = 32'd0;
                    r_next.quotient  = 32'd0;
                    r_next.counter   = 5'd31;
                    r_next.state     = BUSY;
`ifdef DIV_EARLY_OUT_EN
                    // Preload the final quotient/remainder magnitudes; DONE applies signs
                    if (dvs_abs == 32'd0) begin
                        r_next.quotient  = 32'hFFFF_FFFF;
                        r_next.remainder = dvd_abs;
                        r_next.state     = DONE;
                    end else if (ovf_in) begin
                        r_next.quotient  = 32'h8000_0000;
                        r_next.state     = DONE;
                    end else if (dvd_abs < dvs_abs) begin
                        r_next.remainder = dvd_abs;
                        r_next.state     = DONE;
                    end
`else
`endif
                end
            end
            BUSY: begin
                if (!div_in.enable) begin
                    r_next.state = IDLE;
                end else begin
                    r_next.remainder = step_rem;
                    r_next.dividend  = {r_reg.dividend[30:0], 1'b0};
                    r_next.quotient  = {r_reg.quotient[30:0], step_q};
                    if (r_reg.counter == 5'd0)
                        r_next.state = DONE;
                    else
                        r_next.counter = r_reg.counter - 5'd1;
                end
            end
            DONE: begin
                r_next.ready  = 1'b1;
                r_next.result = r_reg.sel_rem ? rem_fix : q_fix;
                r_next.state  = IDLE;
            end
            default: begin
                r_next = init_div_reg;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst)
            r_reg <= init_div_reg;
        else
            r_reg <= r_next;
    end

    assign div_out.ready  = r_reg.ready;
    assign div_out.result = r_reg.result;

endmodule

// File: tb/tb_div_iterative.sv
// Self-checking bench for div_iterative: scoreboard of expected result/latency
// per operation, plus abort, mid-operation reset and back-to-back scenarios.
module tb_div_iterative;
    import wires::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    div_in_type  div_in;
    div_out_type div_out;

    div_iterative dut (
        .rst     (rst),
        .clk     (clk),
        .div_in  (div_in),
        .div_out (div_out)
    );

    always #5 clk = ~clk;

    localparam div_op_type OP_DIV  = 4'b1000;
    localparam div_op_type OP_DIVU = 4'b0100;
    localparam div_op_type OP_REM  = 4'b0010;
    localparam div_op_type OP_REMU = 4'b0001;

    typedef struct {
        logic [31:0] result;
        int          lat;
        string       name;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    function automatic logic [31:0] model(input div_op_type op, input logic [31:0] a, input logic [31:0] b);
        logic ovf;
        ovf = (op.div | op.rem) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (op.divu) return (b == 0) ? 32'hFFFF_FFFF : a / b;
        if (op.remu) return (b == 0) ? a : a % b;
        if (op.div) begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf) return 32'h8000_0000;
            return $signed(a) / $signed(b);
        end
        if (b == 0) return a;
        if (ovf) return 32'd0;
        return $signed(a) % $signed(b);
    endfunction

    function automatic int latency(input div_op_type op, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
        logic        sgn;
        logic [31:0] ma;
        logic [31:0] mb;
        sgn = op.div | op.rem;
        ma  = (sgn && a[31]) ? -a : a;
        mb  = (sgn && b[31]) ? -b : b;
        if (b == 0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || ma < mb)
            return 1;
`else
`endif
        return 33;
    endfunction

    // Starts an operation, scrambles operands while busy, waits for ready and
    // checks latency/result; unless hold, drops enable and checks the pulse ends.
    task automatic do_op(input div_op_type op, input logic [31:0] a, input logic [31:0] b,
                         input string name, input bit hold);
        exp_t e;
        int   k;
        e.result = model(op, a, b);
        e.lat    = latency(op, a, b);
        e.name   = name;
        sb.push_back(e);
        div_in.op     = op;
        div_in.rdata1 = a;
        div_in.rdata2 = b;
        div_in.enable = 1'b1;
        @(posedge clk); #1;
        div_in.rdata1 = ~a;
        div_in.rdata2 = a ^ 32'h0000_5A5A;
        div_in.op     = OP_REMU;
        k = 0;
        for (int i = 1; i <= 80; i++) begin
            @(posedge clk); #1;
            if (div_out.ready) begin
                k = i;
                break;
            end
        end
        e = sb.pop_front();
        total++;
        if (k == 0) begin
            bad++;
            $display("FAIL %s timeout: ready never seen, required latency %0d", e.name, e.lat);
        end else begin
            $display("op %s a=%h b=%h result=%h latency=%0d", e.name, a, b, div_out.result, k);
            total++;
            if (k !== e.lat) begin
                bad++;
                $display("FAIL %s latency: got %0d required %0d", e.name, k, e.lat);
            end
            total++;
            if (div_out.result !== e.result) begin
                bad++;
                $display("FAIL %s result: got %h required %h", e.name, div_out.result, e.result);
            end
        end
        if (!hold) begin
            div_in.enable = 1'b0;
            @(posedge clk); #1;
            total++;
            if (div_out.ready !== 1'b0) begin
                bad++;
                $display("FAIL %s pulse: ready got %b required 0", e.name, div_out.ready);
            end
            total++;
            if (div_out.result !== e.result) begin
                bad++;
                $display("FAIL %s hold: result got %h required %h", e.name, div_out.result, e.result);
            end
        end
    endtask

    task automatic test_reset();
        div_in = '0;
        rst    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (div_out.ready !== 1'b0) begin
            bad++;
            $display("FAIL reset ready: got %b required 0", div_out.ready);
        end
        total++;
        if (div_out.result !== 32'd0) begin
            bad++;
            $display("FAIL reset result: got %h required 00000000", div_out.result);
        end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned();
        do_op(OP_DIVU, 32'd100, 32'd7, "divu_100_7", 1'b0);
        do_op(OP_REMU, 32'd100, 32'd7, "remu_100_7", 1'b0);
    endtask

    task automatic test_signed();
        do_op(OP_DIV, 32'hFFFF_FF9C, 32'd7, "div_m100_7", 1'b0);
        do_op(OP_REM, 32'hFFFF_FF9C, 32'd7, "rem_m100_7", 1'b0);
        do_op(OP_DIV, 32'd100, 32'hFFFF_FFF9, "div_100_m7", 1'b0);
    endtask

    task automatic test_special();
        do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 1'b0);
        do_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf", 1'b0);
        do_op(OP_DIV, 32'd5, 32'd0, "div_5_0", 1'b0);
        do_op(OP_REM, 32'd5, 32'd0, "rem_5_0", 1'b0);
        do_op(OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, "divu_big", 1'b0);
    endtask

    task automatic test_abort();
        div_in.op     = OP_DIVU;
        div_in.rdata1 = 32'd1000;
        div_in.rdata2 = 32'd3;
        div_in.enable = 1'b1;
        @(posedge clk); #1;
        for (int i = 1; i <= 11; i++) begin
            if (i == 9) div_in.enable = 1'b1;
            @(posedge clk); #1;
            if (i == 9) div_in.enable = 1'b0;
            total++;
            if (div_out.ready !== 1'b0) begin
                bad++;
                $display("FAIL abort ready at N+%0d: got %b required 0", i, div_out.ready);
            end
        end
        do_op(OP_DIVU, 32'd9, 32'd3, "divu_9_3_restart", 1'b0);
    endtask

    task automatic test_reset_mid();
        div_in.op     = OP_DIVU;
        div_in.rdata1 = 32'd1000;
        div_in.rdata2 = 32'd3;
        div_in.enable = 1'b1;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (div_out.ready !== 1'b0) begin
            bad++;
            $display("FAIL midreset ready: got %b required 0", div_out.ready);
        end
        total++;
        if (div_out.result !== 32'd0) begin
            bad++;
            $display("FAIL midreset result: got %h required 00000000", div_out.result);
        end
        rst           = 1'b1;
        div_in.enable = 1'b0;
        @(posedge clk); #1;
        do_op(OP_DIVU, 32'd8, 32'd2, "divu_8_2", 1'b0);
    endtask

    task automatic test_back_to_back();
        do_op(OP_DIVU, 32'd50, 32'd5, "divu_50_5", 1'b1);
        do_op(OP_REMU, 32'd50, 32'd6, "remu_50_6", 1'b0);
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_special();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
